// File: rtl/stat_pkg.sv
// stat_pkg: state encoding, display selection codes and source mux helper for stat_readout_ctrl
package stat_pkg;
    typedef enum logic [1:0] {
        LIVE   = 2'd0,
        FROZEN = 2'd1,
        CLEAR  = 2'd2
    } state_t;

    localparam logic [1:0] SEL_TOTAL    = 2'd0;
    localparam logic [1:0] SEL_COBRANCH = 2'd1;
    localparam logic [1:0] SEL_UNBRANCH = 2'd2;
    localparam logic [1:0] SEL_PC       = 2'd3;

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] a, b, c, d);
        return sel == SEL_TOTAL ? a : sel == SEL_COBRANCH ? b : sel == SEL_UNBRANCH ? c : d;
    endfunction
endpackage

// File: rtl/stat_rotate_timer.sv
// stat_rotate_timer: counts while enabled and pulses expire on the last tick of each rotate period
module stat_rotate_timer #(
    parameter int ROTATE_TICKS = 50_000_000,
    parameter int TW = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic restart,
    output logic expire
);
    localparam logic [TW-1:0] LAST = TW'(ROTATE_TICKS - 1);
    logic [TW-1:0] cnt;
    assign expire = enable && cnt == LAST;
    always_ff @(posedge clk) begin
        if (rst || restart || !enable || expire)
            cnt <= '0;
        else
            cnt <= cnt + TW'(1);
    end
endmodule

// File: rtl/stat_readout_ctrl.sv
// stat_readout_ctrl: sequences statistic clear/freeze and multiplexes counters and PC onto the display bus
module stat_readout_ctrl
    import stat_pkg::*;
#(
    parameter int ROTATE_TICKS = 50_000_000,
    parameter int TW = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic        btn_next,
    input  logic        btn_auto,
    input  logic        btn_clr,
    input  logic [31:0] total_cycle,
    input  logic [31:0] cobranch_cycle,
    input  logic [31:0] unbranch_cycle,
    input  logic [31:0] pc_value,
    output logic        stat_clr,
    output logic [31:0] disp_data,
    output logic [1:0]  disp_sel,
    output logic        frozen,
    output logic        auto_mode
);
    state_t state, state_nx;
    logic halt_d, halt_rise, expire;
    logic [31:0] snap_total, snap_cobranch, snap_unbranch, snap_pc;

    assign halt_rise = halt & ~halt_d;

    always_ff @(posedge clk) begin
        if (rst)
            state <= LIVE;
        else
            state <= state_nx;
    end

    // btn_clr outranks a freeze; CLEAR always falls back to LIVE
    always_comb begin
        state_nx = state == CLEAR ? LIVE :
                   btn_clr ? CLEAR :
                   (state == LIVE && halt_rise) ? FROZEN : state;
    end

    always_comb begin
        stat_clr = state == CLEAR;
        frozen   = state == FROZEN;
    end

    stat_rotate_timer #(.ROTATE_TICKS(ROTATE_TICKS), .TW(TW)) u_timer (
        .clk(clk),
        .rst(rst),
        .enable(auto_mode),
        .restart(btn_auto | btn_next),
        .expire(expire)
    );

    always_ff @(posedge clk) begin
        if (rst || state == CLEAR) begin
            snap_total    <= '0;
            snap_cobranch <= '0;
            snap_unbranch <= '0;
            snap_pc       <= '0;
        end else if (state_nx == FROZEN && state == LIVE) begin
            snap_total    <= total_cycle;
            snap_cobranch <= cobranch_cycle;
            snap_unbranch <= unbranch_cycle;
            snap_pc       <= pc_value;
        end
    end

    // a manual step coinciding with expiry still advances only once
    always_ff @(posedge clk) begin
        if (rst) begin
            halt_d    <= 1'b0;
            auto_mode <= 1'b0;
            disp_sel  <= SEL_TOTAL;
            disp_data <= '0;
        end else begin
            halt_d    <= halt;
            auto_mode <= auto_mode ^ btn_auto;
            disp_sel  <= disp_sel + {1'b0, btn_next | expire};
            disp_data <= frozen ? pick(disp_sel, snap_total, snap_cobranch, snap_unbranch, snap_pc)
                                : pick(disp_sel, total_cycle, cobranch_cycle, unbranch_cycle, pc_value);
        end
    end
endmodule

// File: tb/tb_stat_readout_ctrl.sv
// tb_stat_readout_ctrl: directed test-plan sequences plus random stimulus against a behavioural model
module tb_stat_readout_ctrl;
    localparam int RT = 4;

    logic clk = 0, rst = 1, halt = 0, btn_next = 0, btn_auto = 0, btn_clr = 0;
    logic [31:0] total_cycle = 0, cobranch_cycle = 0, unbranch_cycle = 0, pc_value = 0;
    logic stat_clr, frozen, auto_mode;
    logic [31:0] disp_data;
    logic [1:0] disp_sel;

    stat_readout_ctrl #(.ROTATE_TICKS(RT), .TW(2)) dut (
        .clk(clk), .rst(rst), .halt(halt), .btn_next(btn_next), .btn_auto(btn_auto),
        .btn_clr(btn_clr), .total_cycle(total_cycle), .cobranch_cycle(cobranch_cycle),
        .unbranch_cycle(unbranch_cycle), .pc_value(pc_value), .stat_clr(stat_clr),
        .disp_data(disp_data), .disp_sel(disp_sel), .frozen(frozen), .auto_mode(auto_mode)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    bit m_clearing, m_frozen, m_auto, m_hprev;
    int m_sel, m_tmr;
    logic [31:0] m_snap [4];
    logic [31:0] m_disp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_step();
        logic [31:0] live [4];
        bit expire;
        live[0] = total_cycle; live[1] = cobranch_cycle; live[2] = unbranch_cycle; live[3] = pc_value;
        if (rst) begin
            m_clearing = 0; m_frozen = 0; m_auto = 0; m_hprev = 0;
            m_sel = 0; m_tmr = 0; m_disp = 0;
            for (int i = 0; i < 4; i++) m_snap[i] = 0;
            return;
        end
        m_disp = m_frozen ? m_snap[m_sel] : live[m_sel];
        expire = m_auto && m_tmr == RT - 1;
        m_sel = (m_sel + ((btn_next || expire) ? 1 : 0)) % 4;
        m_tmr = (btn_auto || btn_next || !m_auto) ? 0 : (m_tmr + 1) % RT;
        m_auto = m_auto ^ btn_auto;
        if (m_clearing) begin
            m_clearing = 0;
            m_frozen = 0;
            for (int i = 0; i < 4; i++) m_snap[i] = 0;
        end else if (btn_clr) begin
            m_clearing = 1;
            m_frozen = 0;
        end else if (!m_frozen && halt && !m_hprev) begin
            m_frozen = 1;
            for (int i = 0; i < 4; i++) m_snap[i] = live[i];
        end
        m_hprev = halt;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("stat_clr", stat_clr, m_clearing);
        check("frozen", frozen, m_frozen);
        check("auto_mode", auto_mode, m_auto);
        check("disp_sel", disp_sel, m_sel);
        check("disp_data", disp_data, m_disp);
        btn_next = 0; btn_auto = 0; btn_clr = 0;
    endtask

    initial begin
        int s;
        rst = 1;
        tick(); tick();
        check("reset_data", disp_data, 0);
        check("reset_sel", disp_sel, 0);
        rst = 0;

        total_cycle = 32'h10;
        tick();
        check("live_total", disp_data, 32'h10);
        check("live_frozen", frozen, 0);

        cobranch_cycle = 32'h7; halt = 1;
        tick();
        cobranch_cycle = 32'h9; btn_next = 1;
        tick(); tick();
        check("snap_frozen", frozen, 1);
        check("snap_sel", disp_sel, 1);
        check("snap_data", disp_data, 32'h7);

        btn_clr = 1;
        tick();
        check("clr_pulse", stat_clr, 1);
        tick();
        check("clr_once", stat_clr, 0);
        for (int i = 0; i < 4; i++) tick();
        check("no_refreeze", frozen, 0);

        halt = 0; tick();
        halt = 1; btn_clr = 1;
        tick();
        check("tie_clr", stat_clr, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("tie_nofreeze", frozen, 0);
        end
        halt = 0;

        btn_auto = 1;
        tick();
        for (int i = 0; i < 4 * RT; i++) tick();
        check("rotate_wrap", disp_sel, 1'b1 ? m_sel : 0);
        while (m_tmr != RT - 1) tick();
        s = m_sel;
        btn_next = 1;
        tick();
        check("next_on_expiry", disp_sel, 32'((s + 1) % 4));
        btn_auto = 1;
        tick();
        s = m_sel;
        for (int i = 0; i < 3 * RT; i++) tick();
        check("auto_off_hold", disp_sel, 32'(s));

        btn_auto = 1; tick();
        halt = 1; tick(); tick();
        check("pre_rst_frozen", frozen, 1);
        rst = 1;
        tick();
        check("rst_frozen", frozen, 0);
        check("rst_auto", auto_mode, 0);
        check("rst_sel", disp_sel, 0);
        check("rst_data", disp_data, 0);
        rst = 0; halt = 0;

        for (int i = 0; i < 4000; i++) begin
            total_cycle = $urandom; cobranch_cycle = $urandom;
            unbranch_cycle = $urandom; pc_value = $urandom;
            if ($urandom_range(0, 9) == 0) halt = ~halt;
            btn_next = $urandom_range(0, 7) == 0;
            btn_auto = $urandom_range(0, 15) == 0;
            btn_clr = $urandom_range(0, 19) == 0;
            rst = $urandom_range(0, 299) == 0;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
